// File: rtl/board_io_ctrl.sv
// Board I/O front end: synchronizes and debounces switches with edge pulses, and drives
// LEDs in direct, blink, PWM or off mode from free-running prescaler and PWM counters.
`timescale 1ns/1ps
module board_io_ctrl #(
    parameter int N_SW       = 16,
    parameter int N_LED      = 16,
    parameter int DEB_CYCLES = 500000,
    parameter int BLINK_DIV  = 25000000,
    parameter int PWM_BITS   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_SW-1:0]     sw_i,
    output logic [N_SW-1:0]     sw_o,
    output logic [N_SW-1:0]     sw_rise_o,
    output logic [N_SW-1:0]     sw_fall_o,
    input  logic [N_LED-1:0]    led_i,
    input  logic [1:0]          led_mode_i,
    input  logic [PWM_BITS-1:0] pwm_duty_i,
    output logic [N_LED-1:0]    led_o
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [N_SW-1:0]     sync1_q, sync2_q;
    logic [DW-1:0]       deb_cnt_q [N_SW];
    logic [DW-1:0]       deb_cnt_d [N_SW];
    logic [N_SW-1:0]     sw_q, sw_d, rise_q, rise_d, fall_q, fall_d;
    logic [BW-1:0]       presc_q, presc_d;
    logic                phase_q, phase_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                pwm_on_s;
    logic [N_LED-1:0]    led_q, led_d;

    // Debounce: count consecutive mismatch cycles, commit the new level on the last one
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        sw_d      = sw_q;
        rise_d    = '0;
        fall_d    = '0;
        for (int i = 0; i < N_SW; i++) begin
            if (sync2_q[i] == sw_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_cnt_d[i] = '0;
                sw_d[i]      = sync2_q[i];
                rise_d[i]    = sync2_q[i];
                fall_d[i]    = ~sync2_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
    end

    // Blink prescaler and phase toggle on wrap
    always_comb begin
        if (presc_q == BLINK_LAST) begin
            presc_d = '0;
            phase_d = ~phase_q;
        end else begin
            presc_d = presc_q + BW'(1);
            phase_d = phase_q;
        end
    end

    // PWM counter wraps naturally; LED mode select feeds the output register
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        pwm_on_s  = (pwm_cnt_q < pwm_duty_i);
        case (led_mode_i)
            2'b00:   led_d = led_i;
            2'b01:   led_d = led_i & {N_LED{phase_q}};
            2'b10:   led_d = led_i & {N_LED{pwm_on_s}};
            default: led_d = '0;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_cnt_q <= '{default: '0};
            sw_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            presc_q   <= '0;
            phase_q   <= 1'b0;
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            sync1_q   <= sw_i;
            sync2_q   <= sync1_q;
            deb_cnt_q <= deb_cnt_d;
            sw_q      <= sw_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign sw_o      = sw_q;
    assign sw_rise_o = rise_q;
    assign sw_fall_o = fall_q;
    assign led_o     = led_q;

endmodule
